line_collision_checker: RTL
===========================

// Module: line_collision_checker
// PURPOSE
//   Upstream stage of the occupancy grid in the RRT edge-validation path. Takes a segment between two
//   grid cells, rasterises it with integer Bresenham, and issues one read query per cell to the grid.
//   Collects the in-order r_occupied responses and reports whether any cell on the segment is occupied.
//   Keeps up to MAX_OUTSTANDING queries in flight. Stops issuing at the first occupied response.
// PARAMETERS
//   GRID_WIDTH_LOG2   6  x coordinate width (grid is 2^GRID_WIDTH_LOG2 cells wide)
//   GRID_HEIGHT_LOG2  6  y coordinate width
//   MAX_OUTSTANDING   4  max grid queries issued without a response yet (>=1)
// PORTS
//   clk              in   1    clock
//   rst_n            in   1    async active-low reset
//   start_x          in   GW   segment start x (GW=GRID_WIDTH_LOG2)
//   start_y          in   GH   segment start y (GH=GRID_HEIGHT_LOG2)
//   end_x            in   GW   segment end x
//   end_y            in   GH   segment end y
//   req_vld          in   1    request valid; inputs captured on req_vld && req_rdy
//   req_rdy          out  1    high only in IDLE
//   res_vld          out  1    result valid; held until res_rdy
//   res_rdy          in   1    result accepted
//   res_collision    out  1    1 = some cell on the segment is occupied
//   res_cells        out  M+1  cells checked (M=max(GW,GH)): first-hit index+1, or segment length if free
//   grid_cell_x      out  GW   query x to grid cell_x_in
//   grid_cell_y      out  GH   query y to grid cell_y_in
//   grid_vld_in      out  1    query valid to grid vld_in
//   grid_rdy         in   1    grid rdy; query transfers on grid_vld_in && grid_rdy
//   grid_we          out  1    tied 0 (read-only client)
//   grid_vld_out     in   1    grid response valid; responses return in issue order, cannot be stalled
//   grid_r_occupied  in   1    grid occupancy bit, qualified by grid_vld_out
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, req_rdy=1, res_vld=0, res_collision=0, res_cells=0,
//     grid_vld_in=0, grid_cell_x/y=0, outstanding=0. Responses arriving in IDLE are ignored.
//   Bresenham registers: x,y; sx=+1/-1; sy=+1/-1; dx=|ex-sx_| (>=0); dy=-|ey-sy_| (<=0);
//     err=dx+dy. All are signed, M+2 bits wide, so 2*err cannot overflow.
//   Step after each accepted query, when the current cell is not (end_x,end_y): e2=2*err.
//     If e2>=dy: err+=dy and x+=sx. If e2<=dx: err+=dx and y+=sy (both may apply in the same cycle).
//   States:
//     IDLE:   on req_vld: load registers, x=start_x, y=start_y, clear counters -> WALK.
//     WALK:   grid_vld_in=1 iff outstanding<MAX_OUTSTANDING and no hit seen; grid_cell = (x,y).
//             On accept: if (x,y)==end -> DRAIN, else step. Hit seen (occupied response) -> DRAIN.
//     DRAIN:  grid_vld_in=0. Wait until outstanding==0, counting a response that arrives this cycle.
//             -> RESULT.
//     RESULT: res_vld=1. On res_rdy -> IDLE. req_rdy rises the next cycle.
//   grid_vld_in/grid_cell are registered. They hold stable while grid_vld_in && !grid_rdy.
//     They never change mid-handshake.
//   outstanding: +1 on query accept, -1 on grid_vld_out. Both in the same cycle -> unchanged.
//     Never exceeds MAX_OUTSTANDING.
//   Response k (0-based) occupied and no earlier hit: res_collision=1, res_cells=k+1.
//     Later responses are drained but change neither result field.
//   No hit: res_cells = max(|dx|,|dy|)+1.
//   start==end: exactly one query; res_cells=1.
//   Coordinates never wrap; the walk terminates exactly at end.
//   Throughput: 1 query/cycle when grid_rdy=1 and response latency <= MAX_OUTSTANDING cycles.
//   Reset mid-operation: immediate return to IDLE, all counters cleared. The grid shares rst_n,
//     so no stale responses survive.
// TESTING
//   (0,0)->(5,0), empty grid, grid_rdy=1 -> queries x=0..5 y=0 back-to-back, res_collision=0, res_cells=6.
//   (0,0)->(2,5), empty -> query order (0,0),(0,1),(1,2),(1,3),(2,4),(2,5); res_cells=6.
//   (0,0)->(3,3), cell (2,2) occupied, latency 2 -> res_collision=1, res_cells=3, no query after hit seen.
//   (4,4)->(4,4) -> single query (4,4), res_collision=0, res_cells=1. Then res_rdy held low 5 cycles
//     -> res_vld and results held stable.
//   (7,1)->(0,1), grid_rdy random 50%, latency 3, MAX_OUTSTANDING=2 -> 8 queries x=7..0 in order,
//     grid_cell stable while stalled, outstanding<=2.
//   rst_n pulsed low mid-WALK of (0,0)->(9,9) -> next cycle grid_vld_in=0, req_rdy=1, res_vld=0;
//     a fresh request then completes normally.

Source files
------------

// File: rtl/line_collision_checker.sv
// Bresenham segment walker issuing pipelined occupancy-grid reads.
// Reports whether any cell between start and end is occupied.
module line_collision_checker #(
  parameter int GRID_WIDTH_LOG2  = 6,
  parameter int GRID_HEIGHT_LOG2 = 6,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [GRID_WIDTH_LOG2-1:0]  start_x,
  input  logic [GRID_HEIGHT_LOG2-1:0] start_y,
  input  logic [GRID_WIDTH_LOG2-1:0]  end_x,
  input  logic [GRID_HEIGHT_LOG2-1:0] end_y,
  input  logic                        req_vld,
  output logic                        req_rdy,
  output logic                        res_vld,
  input  logic                        res_rdy,
  output logic                        res_collision,
  output logic [((GRID_WIDTH_LOG2 > GRID_HEIGHT_LOG2) ?
                 GRID_WIDTH_LOG2 : GRID_HEIGHT_LOG2):0] res_cells,
  output logic [GRID_WIDTH_LOG2-1:0]  grid_cell_x,
  output logic [GRID_HEIGHT_LOG2-1:0] grid_cell_y,
  output logic                        grid_vld_in,
  input  logic                        grid_rdy,
  output logic                        grid_we,
  input  logic                        grid_vld_out,
  input  logic                        grid_r_occupied
);
  localparam int GW = GRID_WIDTH_LOG2;
  localparam int GH = GRID_HEIGHT_LOG2;
  localparam int M  = (GW > GH) ? GW : GH;
  localparam int W  = M + 2;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, WALK, DRAIN, RESULT} state_t;

  state_t              state, state_n;
  logic signed [W-1:0] x, y, sx, sy, dx, dy, err, ex, ey;
  logic signed [W-1:0] x_n, y_n, sx_n, sy_n, dx_n, dy_n;
  logic signed [W-1:0] err_n, ex_n, ey_n;
  logic signed [W-1:0] sxe, sye, exe, eye, e2, err_t;
  logic [OW-1:0]       outs, outs_n;
  logic                hit, hit_n, vld_q, vld_n, coll_n;
  logic [M:0]          cells_n;
  logic                acc, rsp, at_end;

  assign req_rdy     = (state == IDLE);
  assign res_vld     = (state == RESULT);
  assign grid_we     = 1'b0;
  assign grid_vld_in = vld_q;
  assign grid_cell_x = x[GW-1:0];
  assign grid_cell_y = y[GH-1:0];

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    sx_n    = sx;
    sy_n    = sy;
    dx_n    = dx;
    dy_n    = dy;
    err_n   = err;
    ex_n    = ex;
    ey_n    = ey;
    hit_n   = hit;
    coll_n  = res_collision;
    cells_n = res_cells;
    err_t   = err;
    sxe     = W'(start_x);
    sye     = W'(start_y);
    exe     = W'(end_x);
    eye     = W'(end_y);
    e2      = err <<< 1;
    acc     = vld_q && grid_rdy;
    rsp     = grid_vld_out && (state != IDLE);
    at_end  = (x == ex) && (y == ey);
    outs_n  = outs + OW'(acc) - OW'(rsp);
    // res_cells counts responses until the first hit, then freezes
    if (rsp && !hit) begin
      cells_n = res_cells + 1'b1;
      if (grid_r_occupied) begin
        coll_n = 1'b1;
        hit_n  = 1'b1;
      end
    end
    unique case (state)
      IDLE: begin
        if (req_vld) begin
          x_n     = sxe;
          y_n     = sye;
          ex_n    = exe;
          ey_n    = eye;
          sx_n    = (exe >= sxe) ? W'(1) : -W'(1);
          sy_n    = (eye >= sye) ? W'(1) : -W'(1);
          dx_n    = (exe >= sxe) ? exe - sxe : sxe - exe;
          dy_n    = (eye >= sye) ? sye - eye : eye - sye;
          err_n   = dx_n + dy_n;
          outs_n  = '0;
          hit_n   = 1'b0;
          coll_n  = 1'b0;
          cells_n = '0;
          state_n = WALK;
        end
      end
      WALK: begin
        if (acc) begin
          if (at_end) begin
            state_n = DRAIN;
          end else begin
            if (e2 >= dy) begin
              err_t = err_t + dy;
              x_n   = x + sx;
            end
            if (e2 <= dx) begin
              err_t = err_t + dx;
              y_n   = y + sy;
            end
            err_n = err_t;
          end
        end
        if (hit_n) state_n = DRAIN;
      end
      DRAIN: begin
        if (outs_n == '0) state_n = RESULT;
      end
      RESULT: begin
        if (res_rdy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    vld_n = (state_n == WALK) && (outs_n < OW'(MAX_OUTSTANDING));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      sx            <= '0;
      sy            <= '0;
      dx            <= '0;
      dy            <= '0;
      err           <= '0;
      ex            <= '0;
      ey            <= '0;
      outs          <= '0;
      hit           <= 1'b0;
      vld_q         <= 1'b0;
      res_collision <= 1'b0;
      res_cells     <= '0;
    end else begin
      state         <= state_n;
      x             <= x_n;
      y             <= y_n;
      sx            <= sx_n;
      sy            <= sy_n;
      dx            <= dx_n;
      dy            <= dy_n;
      err           <= err_n;
      ex            <= ex_n;
      ey            <= ey_n;
      outs          <= outs_n;
      hit           <= hit_n;
      vld_q         <= vld_n;
      res_collision <= coll_n;
      res_cells     <= cells_n;
    end
  end
endmodule
